// File: rtl/fxp_div_seq_pkg.sv
// Shared fixed-point format for the ALU datapath: sign-magnitude, 1 sign, I integer, F fraction bits.
package fxp_pkg;

    localparam int W = 32;
    localparam int F = 15;
    localparam int I = W - 1 - F;

    typedef struct packed {
        logic         sign;
        logic [I-1:0] int_part;
        logic [F-1:0] frac;
    } fxp_t;

    localparam logic [W-2:0] FXP_MAX_MAG = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_div_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module fxp_div_step #(
    parameter int W = 32
) (
    input  logic [W-2:0] rem,
    input  logic         next_bit,
    input  logic [W-2:0] divisor,
    output logic [W-2:0] rem_next,
    output logic         q_bit
);

    logic [W-1:0] t;
    logic [W-1:0] diff;

    // rem < divisor holds on entry, so the kept remainder always fits in W-1 bits
    always_comb begin
        t        = {rem, next_bit};
        diff     = t - {1'b0, divisor};
        q_bit    = (t >= {1'b0, divisor});
        rem_next = q_bit ? diff[W-2:0] : t[W-2:0];
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per clock, start/done handshake.
module fxp_div_seq #(
    parameter int W = fxp_pkg::W,
    parameter int F = fxp_pkg::F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         div_by_zero,
    output logic         overflow
);
    import fxp_pkg::*;

    localparam int IW = W - 1 - F;
    localparam int CW = $clog2(W);

    state_t        state;
    logic [W-2:0]  rem;
    logic [W-2:0]  sh;
    logic [W-2:0]  divisor;
    logic          sgn;
    logic [CW-1:0] cnt;

    logic [W-2:0]  mag_a;
    logic [W-2:0]  mag_b;
    logic          s_in;
    logic [W-2:0]  rem_nxt;
    logic          q_bit;
    logic [W-2:0]  q_nxt;

    assign mag_a = a[W-2:0];
    assign mag_b = b[W-2:0];
    assign s_in  = a[W-1] ^ b[W-1];

    fxp_div_step #(.W(W)) u_step (
        .rem      (rem),
        .next_bit (sh[W-2]),
        .divisor  (divisor),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // sh holds remaining dividend bits at the top and collected quotient bits at the bottom
    assign q_nxt = {sh[W-3:0], q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            rem         <= '0;
            sh          <= '0;
            divisor     <= '0;
            sgn         <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        sgn         <= s_in;
                        divisor     <= mag_b;
                        busy        <= 1'b1;
                        if (mag_b == '0) begin
                            result      <= {s_in & (mag_a != '0), {(W-1){1'b1}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if ((mag_a >> IW) >= mag_b) begin
                            result   <= {s_in, {(W-1){1'b1}}};
                            overflow <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rem   <= mag_a >> IW;
                            sh    <= {mag_a[W-2-F:0], {F{1'b0}}};
                            cnt   <= CW'(W - 2);
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    sh  <= q_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= {sgn & (q_nxt != '0), q_nxt};
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_div_seq.sv
// Scoreboard bench for fxp_div_seq: directed cases plus random operands against an arithmetic model.
module tb_fxp_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         dbz;
    logic         ovf;

    fxp_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (dbz),
        .overflow    (ovf)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        logic         ovf;
        int unsigned  lat;
        int unsigned  s_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] res, input logic z, input logic o, input int unsigned lat);
        exp_t e;
        e.res = res; e.dbz = z; e.ovf = o; e.lat = lat; e.s_cyc = 0;
        return e;
    endfunction

    // Reference: quotient = (|a| * 2^15) / |b| in plain integer arithmetic
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] q;
        logic        s;
        exp_t        e;
        ma = 64'(x[W-2:0]);
        mb = 64'(y[W-2:0]);
        s  = x[W-1] ^ y[W-1];
        if (mb == 0) begin
            e = mk({s & (ma != 0), 31'h7FFF_FFFF}, 1'b1, 1'b0, 0);
        end else begin
            q = (ma * 64'd32768) / mb;
            if (q > 64'h7FFF_FFFF) e = mk({s, 31'h7FFF_FFFF}, 1'b0, 1'b1, 0);
            else                   e = mk({s & (q != 0), q[30:0]}, 1'b0, 1'b0, 31);
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%h expected no done (cycle %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("div_by_zero", 64'(dbz), 64'(e.dbz));
                check("overflow", 64'(ovf), 64'(e.ovf));
                check("latency", 64'(cyc - e.s_cyc), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start-sampling edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b expected 0 within 200 cycles", busy);
        end
        a = x; b = y; start = 1'b1;
        e.s_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%b expected 1 within 100 cycles", done);
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        int           n;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_outputs", 64'({busy, done, dbz, ovf, result}), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 0, 0, 31));
        issue(32'h8003_0000, 32'h0001_0000, mk(32'h8001_8000, 0, 0, 31));
        issue(32'h8003_0000, 32'h8001_0000, mk(32'h0001_8000, 0, 0, 31));
        issue(32'h0000_8000, 32'h0001_8000, mk(32'h0000_2AAA, 0, 0, 31));
        issue(32'h8000_0001, 32'h7FFF_FFFF, mk(32'h0000_0000, 0, 0, 31));
        issue(32'h0001_0000, 32'h8000_0000, mk(32'hFFFF_FFFF, 1, 0, 0));
        issue(32'h0000_0000, 32'h8000_0000, mk(32'h7FFF_FFFF, 1, 0, 0));
        issue(32'h7FFF_0000, 32'h0000_4000, mk(32'h7FFF_FFFF, 0, 1, 0));

        // A start pulse mid-operation must be dropped
        issue(32'h0003_0000, 32'h0000_8000, mk(32'h0003_0000, 0, 0, 31));
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'h0000_8000; b = 32'h0000_0000;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));

        // start held through the done cycle: ignored there, accepted one cycle later
        issue(32'h0000_8000, 32'h0000_8000, mk(32'h0000_8000, 0, 0, 31));
        wait_done();
        a = 32'h8000_8000; b = 32'h0002_0000; start = 1'b1;
        e = mk(32'h8000_2000, 0, 0, 31);
        e.s_cyc = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
        check("busy_in_idle", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation
        issue(32'h1234_5678, 32'h0765_4321, model(32'h1234_5678, 32'h0765_4321));
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop_reset_outputs", 64'({busy, done, dbz, ovf, result}), 64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'h0000_8000, 32'h0001_0000, mk(32'h0000_4000, 0, 0, 31));

        for (int i = 0; i < 40; i++) begin
            x = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
            y = {1'($urandom), 31'($urandom) >> $urandom_range(0, 16)};
            if ($urandom_range(0, 9) == 0) y[W-2:0] = '0;
            issue(x, y, model(x, y));
        end

        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
